// File: rtl/fp_mul_round.sv
// Double-precision multiply back end: exponent add + normalize (S1), round-to-nearest-even + pack (S2).
// Latency 2 cycles, 1 op/cycle; a stalled output holds steady and back-pressures through in_ready.
module fp_mul_round #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_prod,
  input  logic             in_sign,
  input  logic [10:0]      in_exp_a,
  input  logic [10:0]      in_exp_b,
  input  logic             in_nan,
  input  logic             in_inf,
  input  logic             in_zero,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [2:0]       out_flags
);

  typedef struct packed {
    logic             sign;
    logic [12:0]      exp;
    logic [52:0]      mant;
    logic             guard;
    logic             sticky;
    logic             nan;
    logic             inf;
    logic             zero;
    logic [TAG_W-1:0] tag;
  } s1_t;

  logic             s1_valid_q;
  s1_t              s1_q;
  s1_t              s1_d;
  logic             out_valid_q;
  logic [63:0]      out_result_q;
  logic [TAG_W-1:0] out_tag_q;
  logic [2:0]       out_flags_q;

  logic             s1_load;
  logic             s2_load;

  logic signed [12:0] exp_sum;
  logic               round_up;
  logic [53:0]        mant_inc;
  logic [52:0]        mant_rnd;
  logic signed [12:0] exp_rnd;
  logic [63:0]        result_d;
  logic [2:0]         flags_d;

  assign s2_load  = ~out_valid_q | out_ready;
  assign s1_load  = ~s1_valid_q | s2_load;
  assign in_ready = s1_load & ~rst;

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;
  assign out_flags  = out_flags_q;

  // Stage 1: biased exponent sum kept at 13 bits signed so overflow/underflow stay visible.
  always_comb begin
    exp_sum     = $signed({2'b00, in_exp_a}) + $signed({2'b00, in_exp_b}) - 13'sd1023;
    s1_d        = '0;
    s1_d.sign   = in_sign;
    s1_d.nan    = in_nan;
    s1_d.inf    = in_inf;
    s1_d.zero   = in_zero;
    s1_d.tag    = in_tag;
    if (in_prod[105]) begin
      s1_d.exp    = exp_sum + 13'sd1;
      s1_d.mant   = in_prod[105:53];
      s1_d.guard  = in_prod[52];
      s1_d.sticky = |in_prod[51:0];
    end else begin
      s1_d.exp    = exp_sum;
      s1_d.mant   = in_prod[104:52];
      s1_d.guard  = in_prod[51];
      s1_d.sticky = |in_prod[50:0];
    end
  end

  // Stage 2: a carry out of the all-ones mantissa renormalizes to 1.0 with exponent + 1.
  always_comb begin
    round_up = s1_q.guard & (s1_q.sticky | s1_q.mant[0]);
    mant_inc = {1'b0, s1_q.mant} + {53'd0, round_up};
    if (mant_inc[53]) begin
      mant_rnd = mant_inc[53:1];
      exp_rnd  = $signed(s1_q.exp) + 13'sd1;
    end else begin
      mant_rnd = mant_inc[52:0];
      exp_rnd  = $signed(s1_q.exp);
    end

    result_d = {s1_q.sign, exp_rnd[10:0], mant_rnd[51:0]};
    flags_d  = {2'b00, s1_q.guard | s1_q.sticky};
    if (s1_q.nan) begin
      result_d = 64'h7FF8_0000_0000_0000;
      flags_d  = 3'b000;
    end else if (s1_q.inf) begin
      result_d = {s1_q.sign, 11'h7FF, 52'd0};
      flags_d  = 3'b000;
    end else if (s1_q.zero) begin
      result_d = {s1_q.sign, 63'd0};
      flags_d  = 3'b000;
    end else if (exp_rnd >= 13'sd2047) begin
      result_d = {s1_q.sign, 11'h7FF, 52'd0};
      flags_d  = 3'b101;
    end else if (exp_rnd <= 13'sd0) begin
      result_d = {s1_q.sign, 63'd0};
      flags_d  = 3'b011;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_q         <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      out_flags_q  <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_q <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_load) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_result_q <= result_d;
          out_tag_q    <= s1_q.tag;
          out_flags_q  <= flags_d;
        end
      end
    end
  end

  // Product bits above 105 are always zero; the hidden bit after rounding is implied.
  logic unused_bits;
  assign unused_bits = ^{in_prod[127:106], mant_rnd[52]};

endmodule

// File: tb/tb_fp_mul_round.sv
// Scoreboard bench for fp_mul_round: stimulus pushes expectations, a negedge monitor pops and compares.
module tb_fp_mul_round;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_prod;
  logic             in_sign;
  logic [10:0]      in_exp_a;
  logic [10:0]      in_exp_b;
  logic             in_nan;
  logic             in_inf;
  logic             in_zero;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic [2:0]       out_flags;

  fp_mul_round #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_prod(in_prod), .in_sign(in_sign),
    .in_exp_a(in_exp_a), .in_exp_b(in_exp_b),
    .in_nan(in_nan), .in_inf(in_inf), .in_zero(in_zero),
    .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0]     prod;
    logic             sign;
    logic [10:0]      ea;
    logic [10:0]      eb;
    logic             nan;
    logic             inf;
    logic             zero;
    logic [TAG_W-1:0] tag;
  } op_t;

  typedef struct packed {
    logic [63:0]      res;
    logic [2:0]       fl;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   rand_bp = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: take the top 53 significant bits, compare the discarded remainder against half an ulp.
  function automatic exp_t model(input op_t op);
    exp_t         r;
    int           e;
    int           sh;
    logic [127:0] q;
    logic [127:0] rem;
    logic [127:0] half;
    r.tag = op.tag;
    r.fl  = 3'b000;
    if (op.nan)       r.res = 64'h7FF8_0000_0000_0000;
    else if (op.inf)  r.res = {op.sign, 11'h7FF, 52'd0};
    else if (op.zero) r.res = {op.sign, 63'd0};
    else begin
      e    = int'(op.ea) + int'(op.eb) - 1023;
      sh   = op.prod[105] ? 53 : 52;
      e    = e + sh - 52;
      q    = op.prod >> sh;
      rem  = op.prod - (q << sh);
      half = 128'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 128'd1;
      if (q[53]) begin
        q = q >> 1;
        e = e + 1;
      end
      if (e >= 2047) begin
        r.res = {op.sign, 11'h7FF, 52'd0};
        r.fl  = 3'b101;
      end else if (e <= 0) begin
        r.res = {op.sign, 63'd0};
        r.fl  = 3'b011;
      end else begin
        r.res = {op.sign, 11'(e), q[51:0]};
        r.fl  = {2'b00, rem != 128'd0};
      end
    end
    return r;
  endfunction

  function automatic op_t mk(input logic [127:0] prod, input logic sign, input int ea, input int eb,
                             input logic nan, input logic inf, input logic zero, input int tag);
    op_t o;
    o.prod = prod; o.sign = sign; o.ea = 11'(ea); o.eb = 11'(eb);
    o.nan = nan; o.inf = inf; o.zero = zero; o.tag = TAG_W'(tag);
    return o;
  endfunction

  function automatic exp_t lit(input logic [63:0] res, input logic [2:0] fl, input int tag);
    exp_t x;
    x.res = res; x.fl = fl; x.tag = TAG_W'(tag);
    return x;
  endfunction

  function automatic op_t rand_op();
    logic [52:0] a;
    logic [52:0] b;
    op_t         o;
    int          k;
    a = {1'b1, 20'($urandom), 32'($urandom)};
    b = {1'b1, 20'($urandom), 32'($urandom)};
    if ($urandom_range(0, 3) == 0) o.prod = (128'(a) << 52) | (128'd1 << 51);
    else                           o.prod = 128'(a) * 128'(b);
    k = int'($urandom_range(0, 3));
    case (k)
      0: begin o.ea = 11'($urandom); o.eb = 11'($urandom); end
      1: begin o.ea = 11'($urandom_range(1, 60));     o.eb = 11'($urandom_range(960, 1030)); end
      2: begin o.ea = 11'($urandom_range(2000, 2046)); o.eb = 11'($urandom_range(1015, 1030)); end
      default: begin o.ea = 11'($urandom_range(900, 1150)); o.eb = 11'($urandom_range(900, 1150)); end
    endcase
    k = int'($urandom_range(0, 15));
    o.nan  = (k == 0);
    o.inf  = (k == 1) || (k == 0 && $urandom_range(0, 1) == 1);
    o.zero = (k == 2) || (k <= 1 && $urandom_range(0, 1) == 1);
    o.sign = 1'($urandom);
    o.tag  = TAG_W'($urandom);
    return o;
  endfunction

  task automatic drive(input op_t op);
    in_prod = op.prod; in_sign = op.sign; in_exp_a = op.ea; in_exp_b = op.eb;
    in_nan = op.nan; in_inf = op.inf; in_zero = op.zero; in_tag = op.tag;
    in_valid = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge with in_valid dropped.
  task automatic issue(input op_t op, input exp_t e);
    int n = 0;
    drive(op);
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        break;
      end
      @(posedge clk); #1;
      if (rand_bp) out_ready = ($urandom_range(0, 2) != 0);
      n++;
      if (n > 200) begin
        total++; bad++;
        $display("FAIL accept_timeout: in_ready stuck low, required high within 200 cycles");
        in_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  // Monitor: pops on every output transfer and checks that a stalled output does not move.
  logic             stall_prev = 1'b0;
  logic [63:0]      prev_res;
  logic [TAG_W-1:0] prev_tag;
  logic [2:0]       prev_fl;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (stall_prev) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_result", out_result, prev_res);
        check("hold_tag", 64'(out_tag), 64'(prev_tag));
        check("hold_flags", 64'(out_flags), 64'(prev_fl));
      end
      stall_prev = (out_valid === 1'b1) && (out_ready === 1'b0) && (rst === 1'b0);
      prev_res = out_result; prev_tag = out_tag; prev_fl = out_flags;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_output: result %h tag %0d presented, required no output", out_result, out_tag);
        end else begin
          e = sb.pop_front();
          check("result", out_result, e.res);
          check("flags", 64'(out_flags), 64'(e.fl));
          check("tag", 64'(out_tag), 64'(e.tag));
        end
      end
    end
  end

  initial begin
    op_t op;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_prod = '0; in_sign = 1'b0; in_exp_a = '0; in_exp_b = '0;
    in_nan = 1'b0; in_inf = 1'b0; in_zero = 1'b0; in_tag = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", out_result, 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_out_flags", 64'(out_flags), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // 1.5 * 2.0 with exact latency check on an idle pipeline.
    issue(mk(128'h18000000000000 * 128'h10000000000000, 1'b0, 1023, 1024, 0, 0, 0, 7),
          lit(64'h4008_0000_0000_0000, 3'b000, 7));
    @(negedge clk);
    check("latency_cycle1_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("latency_cycle2_valid", 64'(out_valid), 64'd1);
    drain();

    issue(mk((128'd1 << 104) | (128'd1 << 51), 0, 1023, 1023, 0, 0, 0, 1), lit(64'h3FF0_0000_0000_0000, 3'b001, 1));
    issue(mk((128'd1 << 104) | (128'd1 << 52) | (128'd1 << 51), 0, 1023, 1023, 0, 0, 0, 2),
          lit(64'h3FF0_0000_0000_0002, 3'b001, 2));
    issue(mk(128'd1 << 104, 0, 2046, 2046, 0, 0, 0, 3), lit(64'h7FF0_0000_0000_0000, 3'b101, 3));
    issue(mk(128'd1 << 104, 0, 1, 1, 0, 0, 0, 4), lit(64'h0000_0000_0000_0000, 3'b011, 4));
    issue(mk(128'd1 << 104, 0, 5, 5, 1, 1, 0, 5), lit(64'h7FF8_0000_0000_0000, 3'b000, 5));
    issue(mk(128'd1 << 104, 1, 5, 5, 0, 0, 1, 6), lit(64'h8000_0000_0000_0000, 3'b000, 6));
    issue(mk(128'd1 << 104, 1, 5, 5, 0, 1, 1, 8), lit(64'hFFF0_0000_0000_0000, 3'b000, 8));
    issue(mk(128'd1 << 105, 0, 1023, 1023, 0, 0, 0, 9), lit(64'h4000_0000_0000_0000, 3'b000, 9));
    issue(mk(({53'h1F_FFFF_FFFF_FFFF, 52'd0}) | (128'd1 << 51), 1, 1023, 1023, 0, 0, 0, 10),
          lit(64'hC000_0000_0000_0000, 3'b001, 10));
    issue(mk(({53'h1F_FFFF_FFFF_FFFF, 52'd0}) | (128'd1 << 51), 0, 2046, 1023, 0, 0, 0, 11),
          lit(64'h7FF0_0000_0000_0000, 3'b101, 11));
    issue(mk(128'd1 << 104, 0, 1, 1023, 0, 0, 0, 12), lit(64'h0010_0000_0000_0000, 3'b000, 12));
    issue(mk(128'd1 << 104, 1, 1, 1022, 0, 0, 0, 13), lit(64'h8000_0000_0000_0000, 3'b011, 13));
    drain();

    // Backpressure: two accepts fill the pipe, the third waits, then all drain in order.
    out_ready = 1'b0;
    op = mk(128'd1 << 104, 0, 1023, 1023, 0, 0, 0, 1);
    issue(op, model(op));
    op = mk(128'd3 << 103, 0, 1000, 1030, 0, 0, 0, 2);
    issue(op, model(op));
    op = mk(128'd1 << 105, 1, 1100, 900, 0, 0, 0, 3);
    drive(op);
    @(negedge clk);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    repeat (2) @(negedge clk);
    check("bp_in_ready_still_low", 64'(in_ready), 64'd0);
    check("bp_head_tag", 64'(out_tag), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_release", 64'(in_ready), 64'd1);
    if (in_ready === 1'b1) sb.push_back(model(op));
    check("bp_order_1", {32'd0, 31'd0, out_valid, 27'd0, out_tag}, {32'd0, 31'd0, 1'b1, 27'd0, 5'd1});
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_order_2", {32'd0, 31'd0, out_valid, 27'd0, out_tag}, {32'd0, 31'd0, 1'b1, 27'd0, 5'd2});
    @(negedge clk);
    check("bp_order_3", {32'd0, 31'd0, out_valid, 27'd0, out_tag}, {32'd0, 31'd0, 1'b1, 27'd0, 5'd3});
    drain();

    // Reset with two operations in flight: both must vanish.
    out_ready = 1'b0;
    op = mk(128'd1 << 104, 0, 1023, 1023, 0, 0, 0, 20);
    issue(op, model(op));
    op = mk(128'd1 << 104, 0, 1023, 1024, 0, 0, 0, 21);
    issue(op, model(op));
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("rst_in_ready_during", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst_flush_out_valid", 64'(out_valid), 64'd0);
    check("rst_flush_in_ready", 64'(in_ready), 64'd1);
    repeat (6) @(negedge clk);
    check("rst_no_stale_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // Randomized traffic with random backpressure and idle gaps.
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        out_ready = ($urandom_range(0, 2) != 0);
      end
      op = rand_op();
      issue(op, model(op));
    end
    rand_bp = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete, %0d checks made", total);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fp_mul_round.md
FP_MUL_ROUND -- requirements
Module: fp_mul_round

Interface
REQ-001 Parameter: TAG_W, default 5, width of the reservation-station/ROB tag carried with each operation.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream holds a valid product/operand set.
REQ-005 in_ready  output  1  block accepts the input this cycle; transfer occurs when in_valid & in_ready.
REQ-006 in_prod  input  128  unsigned product from wallace64 of two 64-bit-padded significands (hidden bit at [52]); meaningful bits [105:0].
REQ-007 in_sign  input  1  result sign (sign_a XOR sign_b).
REQ-008 in_exp_a, in_exp_b  input  11 each  biased operand exponents.
REQ-009 in_nan, in_inf, in_zero  input  1 each  special-case flags from unpack stage (inf*0 arrives as in_nan).
REQ-010 in_tag  input  TAG_W  operation tag.
REQ-011 out_valid  output  1  out_result/out_tag/out_flags valid.
REQ-012 out_ready  input  1  downstream (CDB arbiter) accepts; transfer when out_valid & out_ready.
REQ-013 out_result  output  64  IEEE-754 double result.
REQ-014 out_tag  output  TAG_W  tag of the accepted input, unchanged.
REQ-015 out_flags  output  3  {overflow, underflow, inexact}.

Function
REQ-016 Two-stage pipeline: S1 = exponent add + normalize; S2 = round + pack; latency exactly 2 cycles from accept to out_valid when not stalled; throughput 1/cycle.
REQ-017 Advance rules: S2 loads when !s2_valid | out_ready; S1 loads when !s1_valid | S2 loads; in_ready = S1-load condition and 0 while rst high.
REQ-018 Stall: with out_valid & !out_ready, out_result/out_tag/out_flags held stable; no entry dropped, duplicated or reordered.
REQ-019 Exponent: e = in_exp_a + in_exp_b - 1023, 13-bit signed, no truncation.
REQ-020 Normalize: prod[105]=1 -> mant=prod[105:53], guard=prod[52], sticky=|prod[51:0], e=e+1; else mant=prod[104:52], guard=prod[51], sticky=|prod[50:0].
REQ-021 Round to nearest even: up = guard & (sticky | mant[0]); mant+1 carrying out of bit 52 -> mant=1.0, e=e+1.
REQ-022 inexact = guard | sticky on the normal path.
REQ-023 Overflow: post-round e >= 2047 -> {sign, 0x7FF, 52'b0}, flags overflow=1, inexact=1.
REQ-024 Underflow: post-round e <= 0 -> signed zero (flush, no denormals), underflow=1, inexact=1.
REQ-025 Specials, priority nan > inf > zero > normal: nan -> 0x7FF8000000000000; inf -> signed infinity; zero -> signed zero; all flags 0 on special paths.
REQ-026 Normal result: {sign, e[10:0], mant[51:0]}.

Reset
REQ-027 rst high at a clock edge clears s1_valid, s2_valid, out_valid, out_result, out_tag, out_flags to 0; in-flight operations are discarded, none emitted after reset.
REQ-028 First accept possible the cycle after rst deasserts (in_ready=1).

Verification
REQ-029 exp_a=1023, exp_b=1024, prod=0x18000000000000*0x10000000000000, sign 0 -> 0x4008000000000000, flags 000, out_valid exactly 2 cycles after accept.
REQ-030 exps 1023/1023, prod=(1<<104)|(1<<51) -> 0x3FF0000000000000, inexact=1; prod=(1<<104)|(1<<52)|(1<<51) -> 0x3FF0000000000002, inexact=1.
REQ-031 exps 2046/2046, prod=1<<104 -> 0x7FF0000000000000, flags 101; exps 1/1 -> 0x0000000000000000, flags 011.
REQ-032 in_nan=1 with in_inf=1 -> 0x7FF8000000000000; in_zero=1, sign 1 -> 0x8000000000000000; flags 000.
REQ-033 out_ready=0, three back-to-back inputs tags 1,2,3 -> in_ready low after two accepts, outputs held; out_ready=1 -> tags 1,2,3 in order, one per cycle.
REQ-034 rst asserted with two ops in flight -> out_valid 0 next cycle, no stale result emitted afterward.
